dm_cache: RTL
=============

DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 SHALL have parameter LINES, default 16, number of one-word cache lines; power of two, 2..256.
REQ-002 SHALL have parameter CACHE_LIMIT, default 32'h0001_0000, first non-cacheable byte address.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_valid  input  1  CPU request valid, picorv32 native bus.
REQ-006 SHALL have port mem_instr  input  1  request is an instruction fetch; ignored functionally.
REQ-007 SHALL have port mem_addr  input  32  CPU byte address; word-aligned.
REQ-008 SHALL have port mem_wdata  input  32  CPU write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte strobes; 0 = read.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse to the CPU.
REQ-011 SHALL have port mem_rdata  output  32  read data; valid while mem_ready=1.
REQ-012 SHALL have port mm_valid  output  1  request to backing memory.
REQ-013 SHALL have port mm_ready  input  1  backing memory completion.
REQ-014 SHALL have port mm_addr, mm_wdata, mm_wstrb  output  32/32/4  backing request fields.
REQ-015 SHALL have port mm_rdata  input  32  backing read data; valid when mm_ready=1.
REQ-016 SHALL have port hit_count, miss_count  output  32/32  read statistics for the display path.

Function
REQ-017 SHALL be direct-mapped, one 32-bit word per line: index = mem_addr[IDX+1:2], tag = mem_addr[31:IDX+2], IDX = log2(LINES); one valid bit per line.
REQ-018 SHALL treat mem_addr < CACHE_LIMIT as cacheable; all other addresses bypass the cache and never touch tag, data or valid arrays.
REQ-019 SHALL implement states IDLE, READ_MM, WRITE_MM, RESP.
REQ-020 IDLE, mem_valid=1, cacheable read, valid and tag match (hit): load mem_rdata from the data array, go RESP; mem_ready=1 exactly one cycle after first sampling mem_valid.
REQ-021 IDLE, read miss or uncached read: register mm_addr=mem_addr, mm_wstrb=0, assert mm_valid next cycle, go READ_MM.
REQ-022 IDLE, mem_wstrb!=0 (any address): register mm_addr, mm_wdata, mm_wstrb from CPU, assert mm_valid, go WRITE_MM (write-through, no write-allocate).
REQ-023 READ_MM: hold mm_valid and all mm_* fields stable until mm_ready sampled 1; on that edge deassert mm_valid, capture mm_rdata into mem_rdata, go RESP; if cacheable, also write the word into the line, set tag, set valid.
REQ-024 WRITE_MM: hold mm_* stable until mm_ready; on that edge deassert mm_valid, go RESP; if cacheable and line hit at request time, merge strobed bytes into the cached word; miss leaves the line untouched.
REQ-025 RESP: mem_ready=1 for exactly one cycle, then IDLE; mem_ready SHALL never be high in any other state.
REQ-026 IDLE SHALL accept a new request the cycle after RESP; back-to-back hits therefore complete every 2 cycles.
REQ-027 mm_ready while mm_valid=0 SHALL be ignored.
REQ-028 hit_count SHALL increment by 1 per cacheable read hit, miss_count per cacheable read miss, both at the IDLE decision edge; writes and uncached reads count nothing.
REQ-029 Counters SHALL saturate at 32'hFFFF_FFFF (no wrap).
REQ-030 mm_valid, mm_addr, mm_wdata, mm_wstrb, mem_ready, mem_rdata SHALL be registered outputs.

Reset
REQ-031 resetn=0 at a clock edge SHALL force state IDLE, all valid bits 0, mem_ready=0, mm_valid=0, mm_addr=mm_wdata=0, mm_wstrb=0, mem_rdata=0, hit_count=miss_count=0.
REQ-032 Reset mid READ_MM/WRITE_MM SHALL drop mm_valid the next cycle and abandon the transfer without updating any line.
REQ-033 Data and tag arrays need no reset; only valid bits gate hits.

Verification
REQ-034 After reset, read 0x0000_0040, mm_rdata=0xDEAD_BEEF after 3-cycle mm_ready delay -> mem_ready one pulse with 0xDEAD_BEEF, miss_count=1; repeat read -> mem_ready 1 cycle after valid, no mm_valid, hit_count=1.
REQ-035 Line conflict (LINES=16): read 0x40 then 0x80 then 0x40 -> three misses, miss_count=3, each refill on mm bus.
REQ-036 Write 0x0000_0040 data 0x1122_3344 strobe 4'b0011 after line cached as 0xDEAD_BEEF -> mm write issued with strobe 0011, subsequent read hits with 0xDEAD_3344.
REQ-037 Read and write to 0x1000_0000 -> every access on mm bus, counters unchanged, repeated read still goes to mm.
REQ-038 Assert resetn=0 while mm_valid=1 waiting on mm_ready -> mm_valid 0 next cycle, previously filled line now misses, counters 0.
REQ-039 Force hit_count to saturation via long hit loop (or preload in simulation) -> stays 32'hFFFF_FFFF on further hits.

Source files
------------

// File: rtl/dm_cache.sv
// Direct-mapped, one-word-per-line, write-through/no-write-allocate cache between
// a picorv32 native bus and a backing memory, with saturating read hit/miss counters.
module dm_cache #(
  parameter int unsigned LINES       = 16,
  parameter logic [31:0] CACHE_LIMIT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mm_valid,
  input  logic        mm_ready,
  output logic [31:0] mm_addr,
  output logic [31:0] mm_wdata,
  output logic [3:0]  mm_wstrb,
  input  logic [31:0] mm_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IDX  = $clog2(LINES);
  localparam int unsigned TAGW = 30 - IDX;

  typedef enum logic [1:0] {IDLE, READ_MM, WRITE_MM, RESP} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mm_valid_q, mm_valid_d;
  logic [31:0]       mm_addr_q, mm_addr_d;
  logic [31:0]       mm_wdata_q, mm_wdata_d;
  logic [3:0]        mm_wstrb_q, mm_wstrb_d;
  logic              wr_hit_q, wr_hit_d;
  logic [31:0]       hit_q, hit_d;
  logic [31:0]       miss_q, miss_d;

  logic [IDX-1:0]    req_idx, mm_idx;
  logic [TAGW-1:0]   req_tag, mm_tag;
  logic              req_cacheable, req_hit, mm_cacheable;
  logic              line_we;
  logic [31:0]       line_wdata;

  logic              unused_instr;
  assign unused_instr = mem_instr;

  assign req_idx       = mem_addr[IDX+1:2];
  assign req_tag       = mem_addr[31:IDX+2];
  assign req_cacheable = (mem_addr < CACHE_LIMIT);
  assign req_hit       = req_cacheable && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign mm_idx        = mm_addr_q[IDX+1:2];
  assign mm_tag        = mm_addr_q[31:IDX+2];
  assign mm_cacheable  = (mm_addr_q < CACHE_LIMIT);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    mem_ready_d = mem_ready_q;
    mem_rdata_d = mem_rdata_q;
    mm_valid_d  = mm_valid_q;
    mm_addr_d   = mm_addr_q;
    mm_wdata_d  = mm_wdata_q;
    mm_wstrb_d  = mm_wstrb_q;
    wr_hit_d    = wr_hit_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    line_we     = 1'b0;
    line_wdata  = mm_rdata;

    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (mem_wstrb != 4'b0000) begin
            // Hit status is latched now so the later merge cannot be fooled by the refill path
            mm_valid_d = 1'b1;
            mm_addr_d  = mem_addr;
            mm_wdata_d = mem_wdata;
            mm_wstrb_d = mem_wstrb;
            wr_hit_d   = req_hit;
            state_d    = WRITE_MM;
          end else if (req_hit) begin
            mem_rdata_d = data_q[req_idx];
            mem_ready_d = 1'b1;
            hit_d       = (hit_q == '1) ? hit_q : hit_q + 32'd1;
            state_d     = RESP;
          end else begin
            mm_valid_d = 1'b1;
            mm_addr_d  = mem_addr;
            mm_wstrb_d = '0;
            if (req_cacheable) begin
              miss_d = (miss_q == '1) ? miss_q : miss_q + 32'd1;
            end
            state_d    = READ_MM;
          end
        end
      end
      READ_MM: begin
        if (mm_ready) begin
          mm_valid_d  = 1'b0;
          mem_rdata_d = mm_rdata;
          mem_ready_d = 1'b1;
          state_d     = RESP;
          if (mm_cacheable) begin
            line_we         = 1'b1;
            valid_d[mm_idx] = 1'b1;
          end
        end
      end
      WRITE_MM: begin
        if (mm_ready) begin
          mm_valid_d  = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = RESP;
          if (wr_hit_q) begin
            line_we = 1'b1;
            for (int unsigned b = 0; b < 4; b++) begin
              line_wdata[8*b +: 8] = mm_wstrb_q[b] ? mm_wdata_q[8*b +: 8] : data_q[mm_idx][8*b +: 8];
            end
          end
        end
      end
      RESP: begin
        mem_ready_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      mm_valid_q  <= 1'b0;
      mm_addr_q   <= '0;
      mm_wdata_q  <= '0;
      mm_wstrb_q  <= '0;
      wr_hit_q    <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      mm_valid_q  <= mm_valid_d;
      mm_addr_q   <= mm_addr_d;
      mm_wdata_q  <= mm_wdata_d;
      mm_wstrb_q  <= mm_wstrb_d;
      wr_hit_q    <= wr_hit_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  // Tag/data storage is not reset; valid bits alone decide hits.
  always_ff @(posedge clk) begin
    if (resetn && line_we) begin
      data_q[mm_idx] <= line_wdata;
      tag_q[mm_idx]  <= mm_tag;
    end
  end

  assign mem_ready  = mem_ready_q;
  assign mem_rdata  = mem_rdata_q;
  assign mm_valid   = mm_valid_q;
  assign mm_addr    = mm_addr_q;
  assign mm_wdata   = mm_wdata_q;
  assign mm_wstrb   = mm_wstrb_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule
